// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch/writeback inputs and execute-stage outputs of the decode stage.
interface decode_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           InstrD;
    logic [31:0]           PCD;
    logic [31:0]           PCPlus4D;
    logic                  RegWriteW;
    logic [4:0]            RdW;
    logic [DATA_WIDTH-1:0] ResultW;
    logic                  FlushE;
    logic [4:0]            Rs1D;
    logic [4:0]            Rs2D;
    logic                  RegWriteE;
    logic                  MemWriteE;
    logic                  JumpE;
    logic                  BranchE;
    logic                  BranchNeE;
    logic                  ALUSrcE;
    logic                  JalrE;
    logic [1:0]            ResultSrcE;
    logic [2:0]            ALUControlE;
    logic [DATA_WIDTH-1:0] RD1E;
    logic [DATA_WIDTH-1:0] RD2E;
    logic [DATA_WIDTH-1:0] ImmExtE;
    logic [31:0]           PCE;
    logic [31:0]           PCPlus4E;
    logic [4:0]            Rs1E;
    logic [4:0]            Rs2E;
    logic [4:0]            RdE;
    logic [DATA_WIDTH-1:0] a0;

    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
        input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, BranchNeE, ALUSrcE, JalrE,
               ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, a0
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
        output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, BranchNeE, ALUSrcE, JalrE,
               ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, a0
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode, register file with write-before-read bypass,
// and the decode/execute pipeline register with flush.
module decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       branch_ne;
        logic       alu_src;
        logic       jalr;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } ctrl_t;

    ctrl_t                 ctrl;
    logic [DATA_WIDTH-1:0] rf [REG_COUNT];
    logic [DATA_WIDTH-1:0] imm, imm_i, imm_s, imm_b, imm_j, imm_u, rd1, rd2;
    logic [31:0]           instr;
    logic [6:0]            opcode;
    logic [2:0]            funct3, alu_f3;
    logic [4:0]            rs1, rs2, rd;
    logic                  wen;

    assign instr  = bus.InstrD;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign bus.Rs1D = rs1;
    assign bus.Rs2D = rs2;

    assign alu_f3 = funct3 == 3'b111 ? 3'b010 :
                    funct3 == 3'b110 ? 3'b011 :
                    funct3 == 3'b010 ? 3'b101 : 3'b000;

    assign imm_i = DATA_WIDTH'($signed(instr[31:20]));
    assign imm_s = DATA_WIDTH'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = DATA_WIDTH'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_j = DATA_WIDTH'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_u = DATA_WIDTH'($signed({instr[31:12], 12'b0}));

    always_comb begin
        ctrl = '0;
        imm  = imm_i;
        case (opcode)
            7'b0000011: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = 2'b01;
            end
            7'b0100011: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm            = imm_s;
            end
            7'b0110011: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = (funct3 == 3'b000 && instr[30]) ? 3'b001 : alu_f3;
            end
            7'b0010011: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = alu_f3;
            end
            7'b1100011: begin
                // only beq/bne exist; every other funct3 falls through as a NOP
                ctrl.branch      = funct3[2:1] == 2'b00;
                ctrl.branch_ne   = funct3[2:1] == 2'b00 && funct3[0];
                ctrl.alu_control = funct3[2:1] == 2'b00 ? 3'b001 : 3'b000;
                imm              = imm_b;
            end
            7'b1101111: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = 2'b10;
                imm             = imm_j;
            end
            7'b1100111: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.jalr       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = 2'b10;
            end
            7'b0110111: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = 2'b11;
                imm             = imm_u;
            end
            default: ;
        endcase
    end

    assign wen    = bus.RegWriteW && bus.RdW != 5'd0;
    assign rd1    = rs1 == 5'd0 ? '0 : (wen && bus.RdW == rs1) ? bus.ResultW : rf[rs1];
    assign rd2    = rs2 == 5'd0 ? '0 : (wen && bus.RdW == rs2) ? bus.ResultW : rf[rs2];
    assign bus.a0 = rf[10];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < REG_COUNT; k++) rf[k] <= '0;
        end else if (wen) begin
            rf[bus.RdW] <= bus.ResultW;
        end
    end

    // reset and flush both turn the execute stage into a bubble
    always_ff @(posedge clk) begin
        {bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.BranchE, bus.BranchNeE, bus.ALUSrcE,
         bus.JalrE, bus.ResultSrcE, bus.ALUControlE, bus.RD1E, bus.RD2E, bus.ImmExtE,
         bus.PCE, bus.PCPlus4E, bus.Rs1E, bus.Rs2E, bus.RdE} <= (!rst || bus.FlushE) ? '0 :
            {ctrl, rd1, rd2, imm, bus.PCD, bus.PCPlus4D, rs1, rs2, rd};
    end
endmodule
